leg_intc: RTL and testbench

- Interrupt controller that sources the core's IRQ and FIQ request lines, i.e. the requesting end of the interrupt protocol whose accepting end lives in the pipeline's exception logic.
- Synchronises NSRC peripheral interrupt inputs, latches them as pending, masks and prioritises them, and drives level-held IRQ/FIQ to the core.
- Captures the serviced source ID on the core's one-cycle acknowledge (IRQAssert/FIQAssert) and holds the channel in service until software writes end-of-interrupt over a small memory-mapped register window.

---
 rtl/leg_intc_pkg.sv | 29 ++
 rtl/intc_channel.sv | 82 ++++++++
 rtl/leg_intc.sv | 119 +++++++++++
 tb/tb_leg_intc.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/leg_intc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : leg_intc_pkg
//  Purpose  : Register offsets, EOI bit positions and channel state encoding
//             shared by the leg_intc interrupt controller.
//  Revision : 1.0 - initial release
// ============================================================================
package leg_intc_pkg;

    localparam logic [2:0] C_REG_RAW     = 3'd0;
    localparam logic [2:0] C_REG_PENDING = 3'd1;
    localparam logic [2:0] C_REG_ENABLE  = 3'd2;
    localparam logic [2:0] C_REG_FIQSEL  = 3'd3;
    localparam logic [2:0] C_REG_EDGE    = 3'd4;
    localparam logic [2:0] C_REG_IRQ_ID  = 3'd5;
    localparam logic [2:0] C_REG_FIQ_ID  = 3'd6;
    localparam logic [2:0] C_REG_EOI     = 3'd7;

    localparam int C_EOI_IRQ_BIT = 0;
    localparam int C_EOI_FIQ_BIT = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } chan_state_t;

endpackage
`default_nettype wire

// File: rtl/intc_channel.sv
`default_nettype none
// ============================================================================
//  Module   : intc_channel
//  Purpose  : One request channel (IRQ or FIQ): IDLE/REQ/SERVICE FSM,
//             lowest-index priority encoder and captured ID/valid.
//  Revision : 1.0 - initial release
// ============================================================================
module intc_channel
    import leg_intc_pkg::*;
#(
    parameter int NSRC = 8,
    parameter int IDW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] cand,
    input  logic            Assert,
    input  logic            eoi,
    output logic            req,
    output logic [IDW-1:0]  id,
    output logic            valid,
    output logic [NSRC-1:0] clr_onehot
);

    chan_state_t     r_state;
    chan_state_t     w_state_next;
    logic [IDW-1:0]  r_id;
    logic            r_valid;
    logic [IDW-1:0]  w_win_id;
    logic [NSRC-1:0] w_win_onehot;
    logic            w_any;
    logic            w_take;

    assign w_any        = |cand;
    assign w_win_onehot = cand & (~cand + NSRC'(1));

    always_comb begin
        w_win_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (cand[i]) w_win_id = IDW'(i);
        end
    end

    // Withdrawal takes precedence: an ack with no candidate has nothing to capture.
    assign w_take = (r_state == REQ) && Assert && w_any;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_next = REQ;
            REQ: begin
                if (!w_any)      w_state_next = IDLE;
                else if (Assert) w_state_next = SERVICE;
            end
            SERVICE: if (eoi) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_id    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_take) begin
                r_id    <= w_win_id;
                r_valid <= 1'b1;
            end else if ((r_state == SERVICE) && eoi) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign req        = (r_state == REQ);
    assign id         = r_id;
    assign valid      = r_valid;
    assign clr_onehot = w_take ? w_win_onehot : '0;

endmodule
`default_nettype wire

// File: rtl/leg_intc.sv
`default_nettype none
// ============================================================================
//  Module   : leg_intc
//  Purpose  : Interrupt controller driving level-held IRQ/FIQ to the core,
//             with pending/enable/route/edge registers and EOI handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module leg_intc
    import leg_intc_pkg::*;
#(
    parameter int NSRC = 8,
    parameter int IDW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic            IRQAssert,
    input  logic            FIQAssert,
    input  logic            we,
    input  logic [4:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            IRQ,
    output logic            FIQ
);

    logic [NSRC-1:0] r_sync1, r_s, r_sdly;
    logic [NSRC-1:0] r_pending, r_enable, r_fiqsel, r_edge;
    logic [NSRC-1:0] w_rise, w_w1c, w_clr, w_clr_irq, w_clr_fiq;
    logic [NSRC-1:0] w_cand_irq, w_cand_fiq, w_pend_next, w_wsrc;
    logic [2:0]      w_sel;
    logic            w_eoi_irq, w_eoi_fiq;
    logic [IDW-1:0]  w_irq_id, w_fiq_id;
    logic            w_irq_valid, w_fiq_valid;
    logic            w_unused;

    assign w_sel    = addr[4:2];
    assign w_wsrc   = wdata[NSRC-1:0];
    assign w_unused = ^{addr[1:0], wdata};

    assign w_rise    = r_s & ~r_sdly;
    assign w_w1c     = (we && w_sel == C_REG_PENDING) ? w_wsrc : '0;
    assign w_eoi_irq = we && (w_sel == C_REG_EOI) && wdata[C_EOI_IRQ_BIT];
    assign w_eoi_fiq = we && (w_sel == C_REG_EOI) && wdata[C_EOI_FIQ_BIT];

    assign w_cand_irq = r_pending & r_enable & ~r_fiqsel;
    assign w_cand_fiq = r_pending & r_enable &  r_fiqsel;
    assign w_clr      = w_clr_irq | w_clr_fiq;

    // Edge bits: a new rise beats any clear; level bits just follow the synchronised input.
    assign w_pend_next = (r_edge & ((r_pending & ~w_w1c & ~w_clr) | w_rise))
                       | (~r_edge & r_s);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1   <= '0;
            r_s       <= '0;
            r_sdly    <= '0;
            r_pending <= '0;
            r_enable  <= '0;
            r_fiqsel  <= '0;
            r_edge    <= '0;
        end else begin
            r_sync1   <= irq_src;
            r_s       <= r_sync1;
            r_sdly    <= r_s;
            r_pending <= w_pend_next;
            if (we && w_sel == C_REG_ENABLE) r_enable <= w_wsrc;
            if (we && w_sel == C_REG_FIQSEL) r_fiqsel <= w_wsrc;
            if (we && w_sel == C_REG_EDGE)   r_edge   <= w_wsrc;
        end
    end

    intc_channel #(.NSRC(NSRC), .IDW(IDW)) u_irq_chan (
        .clk        (clk),
        .reset      (reset),
        .cand       (w_cand_irq),
        .Assert     (IRQAssert),
        .eoi        (w_eoi_irq),
        .req        (IRQ),
        .id         (w_irq_id),
        .valid      (w_irq_valid),
        .clr_onehot (w_clr_irq)
    );

    intc_channel #(.NSRC(NSRC), .IDW(IDW)) u_fiq_chan (
        .clk        (clk),
        .reset      (reset),
        .cand       (w_cand_fiq),
        .Assert     (FIQAssert),
        .eoi        (w_eoi_fiq),
        .req        (FIQ),
        .id         (w_fiq_id),
        .valid      (w_fiq_valid),
        .clr_onehot (w_clr_fiq)
    );

    always_comb begin
        rdata = '0;
        case (w_sel)
            C_REG_RAW:     rdata = 32'(r_s);
            C_REG_PENDING: rdata = 32'(r_pending);
            C_REG_ENABLE:  rdata = 32'(r_enable);
            C_REG_FIQSEL:  rdata = 32'(r_fiqsel);
            C_REG_EDGE:    rdata = 32'(r_edge);
            C_REG_IRQ_ID: begin
                rdata[31]      = w_irq_valid;
                rdata[IDW-1:0] = w_irq_id;
            end
            C_REG_FIQ_ID: begin
                rdata[31]      = w_fiq_valid;
                rdata[IDW-1:0] = w_fiq_id;
            end
            default:       rdata = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_leg_intc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_leg_intc
//  Purpose  : Directed self-checking bench for leg_intc.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_leg_intc;

    localparam logic [4:0] A_RAW = 5'd0,  A_PEND = 5'd4,  A_EN  = 5'd8,  A_FSEL = 5'd12;
    localparam logic [4:0] A_EDGE = 5'd16, A_IID = 5'd20, A_FID = 5'd24, A_EOI  = 5'd28;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  irq_src = '0;
    logic        IRQAssert = 1'b0;
    logic        FIQAssert = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        IRQ, FIQ;

    int checks = 0;
    int errors = 0;

    leg_intc #(.NSRC(8), .IDW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .IRQAssert (IRQAssert),
        .FIQAssert (FIQAssert),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .IRQ       (IRQ),
        .FIQ       (FIQ)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        step();
        we = 1'b0; wdata = '0;
    endtask

    task automatic ack(input bit fiq);
        if (fiq) FIQAssert = 1'b1; else IRQAssert = 1'b1;
        step();
        FIQAssert = 1'b0; IRQAssert = 1'b0;
    endtask

    task automatic wait_line(input string tag, input bit fiq);
        for (int i = 0; i < 8 && !(fiq ? FIQ : IRQ); i++) step();
        chk(tag, {31'd0, fiq ? FIQ : IRQ}, 32'd1);
    endtask

    initial begin
        // reset state
        step(); step();
        chk("rst_irq", {31'd0, IRQ}, 32'd0);
        chk("rst_fiq", {31'd0, FIQ}, 32'd0);
        reset = 1'b1;
        rd("rst_pend", A_PEND, 32'h0);
        rd("rst_iid", A_IID, 32'h0);

        // single edge source, latency k+3, ack capture
        wr(A_EN, 32'h01);
        wr(A_EDGE, 32'h01);
        irq_src[0] = 1'b1;
        step();                                   // edge k
        step();                                   // k+1
        step();                                   // k+2
        chk("lat_irq_k2", {31'd0, IRQ}, 32'd0);
        rd("lat_pend_k2", A_PEND, 32'h01);
        step();                                   // k+3
        chk("lat_irq_k3", {31'd0, IRQ}, 32'd1);
        ack(1'b0);
        chk("ack_irq_low", {31'd0, IRQ}, 32'd0);
        rd("ack_iid0", A_IID, 32'h8000_0000);
        rd("ack_pend0", A_PEND, 32'h0);
        wr(A_EOI, 32'h1);
        rd("eoi_iid0", A_IID, 32'h0);

        // priority between sources 2 and 5
        wr(A_EN, 32'h25);
        wr(A_EDGE, 32'h25);
        irq_src = 8'h24;
        wait_line("pri_wait1", 1'b0);
        ack(1'b0);
        rd("pri_iid2", A_IID, 32'h8000_0002);
        rd("pri_pend5", A_PEND, 32'h20);
        step();
        chk("pri_irq_svc", {31'd0, IRQ}, 32'd0);
        wr(A_EOI, 32'h1);
        chk("pri_irq_eoi", {31'd0, IRQ}, 32'd0);
        step();
        chk("pri_irq_rereq", {31'd0, IRQ}, 32'd1);
        ack(1'b0);
        rd("pri_iid5", A_IID, 32'h8000_0005);
        rd("pri_pend_none", A_PEND, 32'h0);
        wr(A_EOI, 32'h1);
        irq_src = 8'h00;

        // FIQ nesting with level source 3 while IRQ services source 1
        wr(A_EN, 32'h0A);
        wr(A_EDGE, 32'h02);
        wr(A_FSEL, 32'h08);
        irq_src[1] = 1'b1;
        wait_line("nest_wait_irq", 1'b0);
        ack(1'b0);
        rd("nest_iid1", A_IID, 32'h8000_0001);
        irq_src[3] = 1'b1;
        wait_line("nest_wait_fiq", 1'b1);
        chk("nest_irq_svc", {31'd0, IRQ}, 32'd0);
        rd("nest_pend3", A_PEND, 32'h08);
        ack(1'b1);
        chk("nest_fiq_low", {31'd0, FIQ}, 32'd0);
        rd("nest_fid3", A_FID, 32'h8000_0003);
        rd("nest_lvl_hold", A_PEND, 32'h08);
        irq_src = 8'h00;
        step(); step(); step();
        rd("nest_lvl_drop", A_PEND, 32'h0);
        wr(A_EOI, 32'h3);
        rd("eoi2_iid", A_IID, 32'h0000_0001);
        rd("eoi2_fid", A_FID, 32'h0000_0003);
        step();
        chk("eoi2_irq", {31'd0, IRQ}, 32'd0);
        chk("eoi2_fiq", {31'd0, FIQ}, 32'd0);

        // withdrawal of source 4 before ack
        wr(A_FSEL, 32'h00);
        wr(A_EN, 32'h10);
        wr(A_EDGE, 32'h10);
        irq_src[4] = 1'b1;
        wait_line("wd_wait", 1'b0);
        wr(A_PEND, 32'h10);
        chk("wd_irq_hold", {31'd0, IRQ}, 32'd1);
        step();
        chk("wd_irq_low", {31'd0, IRQ}, 32'd0);
        ack(1'b0);
        step();
        chk("wd_ack_ign", {31'd0, IRQ}, 32'd0);
        rd("wd_iid", A_IID, 32'h0000_0001);

        // rise and W1C of source 6 in the same cycle
        irq_src = 8'h00;
        wr(A_EN, 32'h00);
        wr(A_EDGE, 32'h40);
        irq_src[6] = 1'b1;
        step();                                   // edge k
        step();                                   // k+1
        wr(A_PEND, 32'h40);                       // k+2: rise coincides with W1C
        rd("rise_w1c", A_PEND, 32'h40);
        wr(A_PEND, 32'h40);
        rd("w1c_clear", A_PEND, 32'h0);
        rd("raw6", A_RAW, 32'h40);

        // reset while FIQ in service
        irq_src = 8'h00;
        wr(A_EN, 32'h80);
        wr(A_EDGE, 32'h80);
        wr(A_FSEL, 32'h80);
        irq_src[7] = 1'b1;
        wait_line("rst_wait_fiq", 1'b1);
        irq_src[7] = 1'b0;
        ack(1'b1);
        rd("svc_fid7", A_FID, 32'h8000_0007);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mrst_fiq", {31'd0, FIQ}, 32'd0);
        chk("mrst_irq", {31'd0, IRQ}, 32'd0);
        rd("mrst_fid", A_FID, 32'h0);
        rd("mrst_en", A_EN, 32'h0);
        rd("mrst_fsel", A_FSEL, 32'h0);
        rd("mrst_edge", A_EDGE, 32'h0);
        rd("mrst_pend", A_PEND, 32'h0);

        // upper bits and EOI readback
        wr(A_EN, 32'hFFFF_FFFF);
        rd("en_hibits", A_EN, 32'h0000_00FF);
        rd("eoi_read", A_EOI, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
